// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder and the memory stage.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_ILL  = 2'b11
  } mem_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } resp_state_t;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // Half accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_type_t typ, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (typ)
      MEM_HALF: mis = addr_lo[0];
      MEM_WORD: mis = (addr_lo != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane alignment: byte enables and lane-replicated store data
// for writes, lane extraction plus sign/zero extension for loads.
import mem_pkg::*;

module mem_lane_align #(
  parameter int DATA_WIDTH = 32
) (
  input  mem_type_t                    typ,
  input  logic                         sign,
  input  logic [1:0]                   addr_lo,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH-1:0]        rword,
  output logic [NUM_LANES-1:0]         be,
  output logic [DATA_WIDTH-1:0]        wdata_sh,
  output logic [DATA_WIDTH-1:0]        rdata_ext
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rword[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    be        = '0;
    wdata_sh  = '0;
    rdata_ext = '0;
    case (typ)
      MEM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {NUM_LANES{wdata[7:0]}};
        rdata_ext = sign ? {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte}
                         : {{(DATA_WIDTH-8){1'b0}}, lane_byte};
      end
      MEM_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {(NUM_LANES/2){wdata[15:0]}};
        rdata_ext = sign ? {{(DATA_WIDTH-16){lane_half[15]}}, lane_half}
                         : {{(DATA_WIDTH-16){1'b0}}, lane_half};
      end
      MEM_WORD: begin
        be        = '1;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      default: begin
        be        = '0;
        wdata_sh  = '0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, valid/ready
// on both request and response sides, byte/half/word accesses with faults.
import mem_pkg::*;

module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [DATA_WIDTH-3:0] WORDS_LIM = MEM_WORDS[DATA_WIDTH-3:0];
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  resp_state_t state, state_nxt;

  logic [3:0]            cnt;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  mem_type_t             r_type;
  logic                  r_sign;

  logic                  err_c;
  logic                  access;
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rword;
  logic [NUM_LANES-1:0]  be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rdata_ext;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Fault check works on the captured request, so it is stable through WAIT.
  assign err_c  = is_misaligned(r_type, r_addr[1:0]) || (r_type == MEM_ILL) ||
                  (r_addr[DATA_WIDTH-1:2] >= WORDS_LIM);
  assign access = (state == WAIT) && (cnt == 4'd0);
  assign idx    = r_addr[AW+1:2];
  assign rword  = mem[idx];

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .typ       (r_type),
    .sign      (r_sign),
    .addr_lo   (r_addr[1:0]),
    .wdata     (r_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: the access edge is the one on which WAIT sees a zero count,
  // which puts resp_valid exactly LATENCY edges after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i)  state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0)  state_nxt = RESP;
      RESP:    if (resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state.
  always_comb begin
    req_ready_o  = (state == IDLE);
    resp_valid_o = (state == RESP);
  end

  // Request capture, latency countdown and response data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_type       <= MEM_BYTE;
      r_sign       <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          r_we    <= req_we_i;
          r_addr  <= req_addr_i;
          r_wdata <= req_wdata_i;
          r_type  <= mem_type_t'(req_type_i);
          r_sign  <= req_sign_i;
          cnt     <= CNT_INIT;
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_err_o   <= err_c;
            resp_rdata_o <= (!r_we && !err_c) ? rdata_ext : '0;
          end
        end
        RESP: if (resp_ready_i) begin
          resp_rdata_o <= '0;
          resp_err_o   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Array write on the access edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (access && r_we && !err_c) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[idx][i*LANE_W +: LANE_W] <= wdata_sh[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DATA_WIDTH=32, MEM_WORDS=1024, LATENCY=2).
module tb_data_mem_responder;

  logic        clk, rst;
  logic        req_valid_i, req_ready_o, req_we_i, req_sign_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_type_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;

  int checks = 0;
  int failures = 0;

  data_mem_responder #(.DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_type_i   (req_type_i),
    .req_sign_i   (req_sign_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from just after a rising edge; returns response and
  // the number of edges from acceptance to resp_valid. Completes the
  // response handshake when resp_ready_i is high.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] typ, input logic sgn,
                        output logic [31:0] rd, output logic er, output int lat);
    bit got;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_type_i  = typ;
    req_sign_i  = sgn;
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid_o) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout: no resp_valid within 20 cycles for addr %h", addr);
    end
    rd = resp_rdata_o;
    er = resp_err_o;
    if (resp_ready_i) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_type_i = 2'b00; req_sign_i = 1'b0; resp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_err", {31'd0, resp_err_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: word store then word load
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
    chk("st_word_lat", lat, 2);
    chk("st_word_rdata", rd, 32'd0);
    chk("st_word_err", {31'd0, er}, 32'd0);
    chk("idle_after_hs", {31'd0, req_ready_o}, 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("ld_word_lat", lat, 2);
    chk("ld_word_rdata", rd, 32'hDEADBEEF);
    chk("ld_word_err", {31'd0, er}, 32'd0);

    // 2: sub-word loads with extension
    do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er, lat);
    chk("ld_byte_s", rd, 32'hFFFFFFDE);
    do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lat);
    chk("ld_byte_u", rd, 32'h000000DE);
    do_req(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, rd, er, lat);
    chk("ld_half_u", rd, 32'h0000BEEF);
    do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, er, lat);
    chk("ld_half_hi_s", rd, 32'hFFFFDEAD);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b1, rd, er, lat);
    chk("ld_word_sign_ignored", rd, 32'hDEADBEEF);

    // 3: byte store touches only its lane
    do_req(1'b1, 32'h11, 32'hAAAAAA55, 2'b00, 1'b0, rd, er, lat);
    chk("st_byte_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("ld_after_byte_st", rd, 32'hDEAD55EF);

    // 4: faults
    do_req(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, rd, er, lat);
    chk("half_mis_err", {31'd0, er}, 32'd1);
    chk("half_mis_rdata", rd, 32'd0);
    do_req(1'b1, 32'h12, 32'h11111111, 2'b10, 1'b0, rd, er, lat);
    chk("word_mis_err", {31'd0, er}, 32'd1);
    chk("word_mis_lat", lat, 2);
    do_req(1'b0, 32'd4096, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
    chk("ill_err", {31'd0, er}, 32'd1);
    chk("ill_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("ld_after_faults", rd, 32'hDEAD55EF);
    chk("ld_after_faults_err", {31'd0, er}, 32'd0);

    // 5: response backpressure, with a store held on the request side
    resp_ready_i = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("bp_first_rdata", rd, 32'hDEAD55EF);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10;
    req_wdata_i = 32'h0BAD0BAD; req_type_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("bp_rdata", resp_rdata_o, 32'hDEAD55EF);
      chk("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("bp_release_rdata", resp_rdata_o, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready_o}, 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("bp_store_ignored", rd, 32'hDEAD55EF);

    // 6: reset during WAIT drops an uncommitted store
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat);
    req_we_i = 1'b1; req_addr_i = 32'h20; req_wdata_i = 32'h12345678;
    req_type_i = 2'b10; req_sign_i = 1'b0; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("wait_req_ready", {31'd0, req_ready_o}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("mid_rst_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("mid_rst_rdata", resp_rdata_o, 32'd0);
    chk("mid_rst_err", {31'd0, resp_err_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("st_dropped", rd, 32'hCAFEF00D);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("st_persist_rst", rd, 32'hDEAD55EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
